// File: rtl/l1_cache_ctrl.sv
// rtl/l1_cache_ctrl.sv - request sequencer for the direct-mapped L1 lookup/update datapath
//
// Accepts one core access at a time, splits the address into tag/index/offset,
// strobes the datapath find, fetches the line from next-level memory on a miss,
// strobes the datapath update to install it, then returns one response.
//
// Optional feature macro: L1_CTRL_STATS_EN (miss-cycle statistics counters).
//
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr          core request handshake
//   resp_valid/resp_ready/resp_hit/resp_data  core response
//   find_start/update_start               one-cycle datapath strobes
//   tag/index/block_offset                registered address fields
//   block                                 line to install
//   found_in_cache/done/hit_data          lookup result (valid while done)
//   updated                               install complete pulse
//   mem_req_valid/mem_req_ready/mem_req_addr  line fill request
//   mem_resp_valid/mem_resp_data          fill data, single beat
//   miss_cycles/max_miss_cycles           statistics (0 unless L1_CTRL_STATS_EN)
module l1_cache_ctrl #(
    parameter int block_size_byte = 16,
    parameter int cache_size_byte = 32768,
    localparam int OFF_W  = $clog2(block_size_byte),
    localparam int IDX_W  = $clog2(cache_size_byte / block_size_byte),
    localparam int TAG_W  = 32 - IDX_W - OFF_W,
    localparam int LINE_W = 8 * block_size_byte
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [LINE_W-1:0] resp_data,
    output logic              find_start,
    output logic              update_start,
    output logic [TAG_W-1:0]  tag,
    output logic [IDX_W-1:0]  index,
    output logic [OFF_W-1:0]  block_offset,
    output logic [LINE_W-1:0] block,
    input  logic              found_in_cache,
    input  logic              done,
    input  logic [LINE_W-1:0] hit_data,
    input  logic              updated,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data,
    output logic [15:0]       miss_cycles,
    output logic [15:0]       max_miss_cycles
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FIND      = 3'd1,
        WAIT_FIND = 3'd2,
        MEM_REQ   = 3'd3,
        MEM_WAIT  = 3'd4,
        UPDATE    = 3'd5,
        WAIT_UPD  = 3'd6,
        RESP      = 3'd7
    } state_t;

    state_t state, state_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; done/updated/mem_resp_valid only matter in their wait states
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (req_valid)      state_nxt = FIND;
            FIND:                          state_nxt = WAIT_FIND;
            WAIT_FIND: if (done)           state_nxt = found_in_cache ? RESP : MEM_REQ;
            MEM_REQ:   if (mem_req_ready)  state_nxt = MEM_WAIT;
            MEM_WAIT:  if (mem_resp_valid) state_nxt = UPDATE;
            UPDATE:                        state_nxt = WAIT_UPD;
            WAIT_UPD:  if (updated)        state_nxt = RESP;
            RESP:      if (resp_ready)     state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Output decode; req_ready is gated by rst so it reads 0 while reset is held
    always_comb begin
        req_ready     = 1'b0;
        find_start    = 1'b0;
        update_start  = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            IDLE:    req_ready     = ~rst;
            FIND:    find_start    = 1'b1;
            MEM_REQ: mem_req_valid = 1'b1;
            UPDATE:  update_start  = 1'b1;
            RESP:    resp_valid    = 1'b1;
            default: ;
        endcase
    end

    // Address fields are latched only on acceptance, so they stay constant
    // until the response handshake returns the FSM to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag          <= '0;
            index        <= '0;
            block_offset <= '0;
            block        <= '0;
            resp_data    <= '0;
            resp_hit     <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                tag          <= req_addr[31:IDX_W+OFF_W];
                index        <= req_addr[IDX_W+OFF_W-1:OFF_W];
                block_offset <= req_addr[OFF_W-1:0];
            end
            if (state == WAIT_FIND && done && found_in_cache) begin
                resp_data <= hit_data;
                resp_hit  <= 1'b1;
            end
            if (state == MEM_WAIT && mem_resp_valid) begin
                block     <= mem_resp_data;
                resp_data <= mem_resp_data;
                resp_hit  <= 1'b0;
            end
        end
    end

    assign mem_req_addr = {tag, index, {OFF_W{1'b0}}};

`ifdef L1_CTRL_STATS_EN
    logic [15:0] miss_cnt;
    logic [15:0] max_cnt;
    logic [15:0] miss_inc;
    logic        in_miss;

    assign in_miss  = (state == MEM_REQ) || (state == MEM_WAIT) ||
                      (state == UPDATE)  || (state == WAIT_UPD);
    assign miss_inc = (miss_cnt == 16'hFFFF) ? miss_cnt : miss_cnt + 16'd1;

    // Cleared on the miss decision so the first MEM_REQ cycle counts as 1;
    // the updated cycle is included via miss_inc when comparing the maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt <= '0;
            max_cnt  <= '0;
        end else begin
            if (state == WAIT_FIND && done && !found_in_cache) begin
                miss_cnt <= '0;
            end else if (in_miss) begin
                miss_cnt <= miss_inc;
            end
            if (state == WAIT_UPD && updated && miss_inc > max_cnt) begin
                max_cnt <= miss_inc;
            end
        end
    end

    assign miss_cycles     = miss_cnt;
    assign max_miss_cycles = max_cnt;
`else
    assign miss_cycles     = 16'd0;
    assign max_miss_cycles = 16'd0;
`endif

endmodule

// File: doc/l1_cache_ctrl.md
# l1_cache_ctrl

Request sequencer for the direct-mapped L1 lookup/update datapath. Accepts one core access at a time and splits the address into tag, index and offset. It pulses the datapath's find and update starts, fetches the line from next-level memory on a miss, installs it, then returns a single response to the core. It sits between the core-side AXI adapter and the cache array, and it is the only block allowed to drive the datapath's start strobes.

## Interface
- `block_size_byte`, 16, line size in bytes; power of two.
- `cache_size_byte`, 32768, cache capacity in bytes.
- `OFF_W`, log2(`block_size_byte`), derived, offset width.
- `IDX_W`, log2(`cache_size_byte`/`block_size_byte`), derived, index width.
- `TAG_W`, 32-`IDX_W`-`OFF_W`, derived, tag width.
- `LINE_W`, 8*`block_size_byte`, derived, line width in bits.

Ports:
- `clk` in 1: the only clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1 / `req_ready` out 1 / `req_addr` in 32: core request handshake.
- `resp_valid` out 1 / `resp_ready` in 1 / `resp_hit` out 1 / `resp_data` out `LINE_W`: core response.
- `find_start` out 1 / `update_start` out 1: one-cycle strobes to the datapath.
- `tag` out `TAG_W` / `index` out `IDX_W` / `block_offset` out `OFF_W`: registered address fields.
- `block` out `LINE_W`: line to install.
- `found_in_cache` in 1 / `done` in 1 / `hit_data` in `LINE_W`: lookup result, valid while `done`=1.
- `updated` in 1: install complete pulse.
- `mem_req_valid` out 1 / `mem_req_ready` in 1 / `mem_req_addr` out 32: line fill request; address is line-aligned.
- `mem_resp_valid` in 1 / `mem_resp_data` in `LINE_W`: fill data, one beat.
- `miss_cycles` out 16 / `max_miss_cycles` out 16: stats (see Configuration).

## Operation
- States: `IDLE`, `FIND`, `WAIT_FIND`, `MEM_REQ`, `MEM_WAIT`, `UPDATE`, `WAIT_UPD`, `RESP`.
- `IDLE`: `req_ready`=1. On `req_valid`, latch `req_addr` into `tag`/`index`/`block_offset` and go to `FIND`.
- `FIND`: `find_start`=1 for exactly one cycle, then go to `WAIT_FIND`.
- `WAIT_FIND`: wait for `done`=1.
  - If `found_in_cache`=1: capture `hit_data` into `resp_data`, set `resp_hit`=1, go to `RESP`.
  - Otherwise: go to `MEM_REQ`.
- `MEM_REQ`: `mem_req_valid`=1 and `mem_req_addr`={`tag`,`index`,`OFF_W`'b0}. Hold both stable until `mem_req_ready`=1, then go to `MEM_WAIT`.
- `MEM_WAIT`: on `mem_resp_valid`, capture `mem_resp_data` into both `block` and `resp_data`, set `resp_hit`=0, go to `UPDATE`.
- `UPDATE`: `update_start`=1 for one cycle, then go to `WAIT_UPD`.
- `WAIT_UPD`: wait for `updated`=1, then go to `RESP`.
- `RESP`: `resp_valid`=1; `resp_hit` and `resp_data` are held stable. On `resp_ready`, go to `IDLE`.
- Only one access is outstanding at a time. `req_ready`=0 in every state except `IDLE`.
- `done`, `updated` and `mem_resp_valid` are ignored in any state that is not waiting for them.
- `tag`, `index` and `block_offset` stay constant from acceptance until the response handshake completes.

## Timing
- Reset values:
  - State `IDLE`.
  - `req_ready`=0 while `rst`=1, and 1 in the first cycle after release.
  - All other outputs 0.
- Reset mid-operation: return to `IDLE` immediately and drop all strobes. Any `done`/`updated` pulse arriving after reset is ignored. An install already started in the datapath may complete; this is accepted.
- Hit latency: accept at cycle 0, `find_start` at cycle 1, datapath `done` at cycle 3, `resp_valid` at cycle 4.
- Miss latency: 4 + (cycles to `mem_req_ready`) + (cycles to `mem_resp_valid`) + 3 cycles before `resp_valid`.
- `req_valid` in the same cycle as a `resp_valid`/`resp_ready` handshake is not accepted. It is accepted the following cycle (the `IDLE` cycle).
- `mem_resp_valid` in the same cycle as `mem_req_ready` is ignored. Fill data is valid only while in `MEM_WAIT`.

## Configuration
- Macro `L1_CTRL_STATS_EN`.
- Defined:
  - `miss_cycles` counts cycles from entering `MEM_REQ` through the `updated` cycle. It is cleared on entering `MEM_REQ` and saturates at 16'hFFFF.
  - `max_miss_cycles` updates to `miss_cycles` on `WAIT_UPD` exit if larger. It is cleared only by `rst`.
- Undefined: both outputs are tied to 0 and no counter registers are built.

## Test plan
- Cold miss: request to 0x0000_1230, memory ready immediately, fill after 5 cycles with 0xA5..A5.
  - Required: fill request at 0x0000_1230, `update_start` one pulse, `resp_hit`=0, `resp_data`=0xA5..A5.
  - With stats: `miss_cycles`=9.
- Hit after fill: same address again -> `resp_valid` 4 cycles after acceptance, `resp_hit`=1, data 0xA5..A5, no memory request.
- Conflict: request 0x0000_9230 (same index, new tag) -> miss, fill, then 0x0000_1230 misses again.
- Backpressure:
  - Hold `mem_req_ready`=0 for 10 cycles -> `mem_req_addr` stable throughout.
  - Hold `resp_ready`=0 for 6 cycles -> response held and `req_ready`=0.
- Reset asserted in `MEM_WAIT`:
  - Outputs go to 0 asynchronously and `req_ready`=1 after release.
  - A late `mem_resp_valid` causes no update.
- Back-to-back: 8 requests with `req_valid` held high -> exactly 8 responses, in order, with no request dropped.
